instruction_loader: RTL and testbench
=====================================

# instruction_loader

Loads a program into instruction memory from a byte stream (host/UART side), assembling three bytes per 24-bit instruction word and writing the words to consecutive addresses from 0. It sits between the host link and the instruction memory that the fetch/decode path reads. While it is loading, it holds the CPU. It stops on the first HALT instruction (opcode 4'hF), on memory overflow, or on a mid-instruction byte timeout.

## Interface
- ADDR_W, 8, instruction memory address width; depth = 2**ADDR_W words
- TIMEOUT, 50000, max idle cycles allowed between bytes of one instruction
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- load_start  input  1  one-cycle pulse; begins a load; ignored while busy
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader can accept a byte
- imem_we  output  1  instruction memory write strobe, one cycle per word
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  24  assembled instruction word
- busy  output  1  load in progress; CPU must be held while high
- load_done  output  1  load ended on HALT; sticky until next load_start
- load_error  output  1  load aborted (overflow or timeout); sticky until next load_start
- instr_count  output  ADDR_W+1  words written in the current/last load

## Operation
- States: IDLE, B0, B1, B2, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + load_start:
  - clear load_done, load_error, instr_count and address
  - go to B0 and assert busy
- Byte ordering is MSB first:
  - B0 captures bits [23:16]
  - B1 captures bits [15:8]
  - B2 captures bits [7:0]
- A byte is accepted only when in_valid && in_ready.
- in_ready is 1 in B0/B1/B2 and 0 in all other states.
- After B2 accepts its byte, go to WRITE. WRITE lasts exactly one cycle:
  - imem_we = 1
  - imem_addr = current address
  - imem_wdata = assembled word
  - instr_count increments
- Exit from WRITE:
  - if word[23:20] == 4'hF → DONE
  - else if address == 2**ADDR_W-1 → ERROR (overflow; the last word is still written)
  - else increment address → B0
- Timeout:
  - The idle counter clears on every accepted byte and on entry to B0.
  - The counter increments in B1/B2 while no byte is accepted.
  - Reaching TIMEOUT-1 → ERROR.
  - B0 has no timeout; the host may pause between instructions.
- DONE: load_done = 1, busy = 0. ERROR: load_error = 1, busy = 0. Both are held until the next load_start.
- Memory contents already written are not rolled back on error.
- busy = 1 in B0, B1, B2 and WRITE.

## Timing
- Reset (async, rst low), all outputs = 0:
  - in_ready, imem_we, imem_addr, imem_wdata, busy, load_done, load_error, instr_count all 0
  - state IDLE
  - idle counter 0
- load_start sampled at edge N: busy and in_ready are high from cycle N+1.
- Third byte accepted at edge N: imem_we is high for cycle N+1 only, with addr/wdata stable during that cycle.
  - in_ready is high again from cycle N+2, unless the load terminates.
- Termination: load_done/load_error rise in the cycle after the WRITE (or timeout) cycle, and busy falls in the same cycle.
- Throughput: at most one instruction per 4 cycles (3 byte cycles + WRITE).
- load_start during busy has no effect. load_start coinciding with a byte in DONE/ERROR starts a new load, and that byte is not accepted (in_ready is 0).
- Reset asserted mid-load: immediate return to IDLE. No further imem_we. A partial word is discarded.

## Test plan
- Two-word load: bytes 10 12 3A, F0 00 00 back-to-back.
  - Expect writes addr0=0x10123A and addr1=0xF00000.
  - load_done=1, instr_count=2, busy=0 one cycle after the second write.
- Backpressure/gaps: the same stream with in_valid toggled every other cycle and gaps < TIMEOUT.
  - Expect identical writes.
  - No byte duplicated or dropped.
- Overflow (ADDR_W=2): 4 non-HALT words.
  - Expect 4 writes at addr 0..3.
  - Then load_error=1, instr_count=4, load_done=0.
- Timeout (TIMEOUT=8): send 2 bytes, then idle.
  - load_error rises 8 cycles after the second byte.
  - No imem_we.
  - A pause of 100 cycles in B0 does not cause an error.
- Mid-load reset: assert rst after byte 2 of word 1.
  - All outputs are 0 asynchronously.
  - No write occurs.
  - A subsequent load_start + F0 00 00 writes addr0=0xF00000.
- load_start pulsed while busy: ignored. Address and count continue unchanged.

Source files
------------

// File: rtl/instruction_loader_if.sv
// rtl/instruction_loader_if.sv - byte stream in and instruction memory write port of the loader
interface instruction_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [23:0]       imem_wdata;

   // host / memory side: drives the stream, observes the writes
   modport master (
      output in_data, in_valid,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   // loader side: consumes the stream, issues the writes
   modport slave (
      input  in_data, in_valid,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - assembles 3-byte instructions from a byte stream and writes them to imem
module instruction_loader #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_start,
   instruction_loader_if.slave  bus,
   output logic                 busy,
   output logic                 load_done,
   output logic                 load_error,
   output logic [ADDR_W:0]      instr_count
);

   // counter only has to reach TIMEOUT-1
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_B0,
      S_B1,
      S_B2,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [23:0]       word_q;
   logic [CNT_W-1:0]  idle_cnt_q;

   logic              ready_c;
   logic              we_c;
   logic              start_c;
   logic              accept;

   assign accept         = bus.in_valid && ready_c;
   assign bus.in_ready   = ready_c;
   assign bus.imem_we    = we_c;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = word_q;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state and state-decoded outputs
   always_comb begin
      state_d    = state_q;
      ready_c    = 1'b0;
      we_c       = 1'b0;
      busy       = 1'b0;
      load_done  = 1'b0;
      load_error = 1'b0;
      start_c    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            load_done  = (state_q == S_DONE);
            load_error = (state_q == S_ERROR);
            if (load_start) begin
               start_c = 1'b1;
               state_d = S_B0;
            end
         end
         S_B0: begin
            busy    = 1'b1;
            ready_c = 1'b1;
            // no timeout here: the host may pause between instructions
            if (bus.in_valid) state_d = S_B1;
         end
         S_B1: begin
            busy    = 1'b1;
            ready_c = 1'b1;
            if (bus.in_valid)                state_d = S_B2;
            else if (idle_cnt_q == CNT_LAST) state_d = S_ERROR;
         end
         S_B2: begin
            busy    = 1'b1;
            ready_c = 1'b1;
            if (bus.in_valid)                state_d = S_WRITE;
            else if (idle_cnt_q == CNT_LAST) state_d = S_ERROR;
         end
         S_WRITE: begin
            busy = 1'b1;
            we_c = 1'b1;
            // HALT wins over overflow; the final word is written either way
            if (word_q[23:20] == 4'hF)  state_d = S_DONE;
            else if (addr_q == ADDR_LAST) state_d = S_ERROR;
            else                          state_d = S_B0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // word assembly, address, count and mid-instruction idle counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q      <= '0;
         word_q      <= '0;
         idle_cnt_q  <= '0;
         instr_count <= '0;
      end else begin
         if (start_c) begin
            addr_q      <= '0;
            instr_count <= '0;
         end
         if (accept) begin
            case (state_q)
               S_B0:    word_q[23:16] <= bus.in_data;
               S_B1:    word_q[15:8]  <= bus.in_data;
               S_B2:    word_q[7:0]   <= bus.in_data;
               default: word_q        <= word_q;
            endcase
         end
         if (state_q == S_WRITE) begin
            instr_count <= instr_count + COUNT_ONE;
            if (state_d == S_B0) addr_q <= addr_q + ADDR_ONE;
         end
         if ((state_q == S_B1 || state_q == S_B2) && !accept) begin
            idle_cnt_q <= idle_cnt_q + CNT_ONE;
         end else begin
            idle_cnt_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - scoreboard bench for instruction_loader
module tb_instruction_loader;

   localparam int ADDR_W  = 2;
   localparam int TIMEOUT = 8;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [23:0]       data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              load_start = 1'b0;
   logic              busy;
   logic              load_done;
   logic              load_error;
   logic [ADDR_W:0]   instr_count;

   int vectors = 0;
   int miscompares = 0;
   wr_t exp_q[$];

   instruction_loader_if #(.ADDR_W(ADDR_W)) bus ();

   instruction_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .bus         (bus),
      .busy        (busy),
      .load_done   (load_done),
      .load_error  (load_error),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // write monitor: every strobe must match the oldest expected write
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", 32'(bus.imem_addr), 32'(e.addr));
            check("write_data", 32'(bus.imem_wdata), 32'(e.data));
         end
      end
   end

   task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [23:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // called just after a falling edge; returns just after the falling edge following acceptance
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("byte_accept_timeout", 32'd0, 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [23:0] w, input bit gaps);
      for (int i = 2; i >= 0; i--) begin
         if (gaps) @(negedge clk);
         send_byte(w[i*8 +: 8]);
      end
   endtask

   task automatic pulse_start;
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_ready",    32'(bus.in_ready), 32'd0);
      check("rst_we",       32'(bus.imem_we), 32'd0);
      check("rst_count",    32'(instr_count), 32'd0);
      check("rst_done",     32'(load_done), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      // two-word load, back to back
      pulse_start();
      check("start_busy",  32'(busy), 32'd1);
      check("start_ready", 32'(bus.in_ready), 32'd1);
      expect_write(2'd0, 24'h10123A);
      expect_write(2'd1, 24'hF00000);
      send_word(24'h10123A, 1'b0);
      send_word(24'hF00000, 1'b0);
      @(negedge clk);
      check("t1_done",  32'(load_done), 32'd1);
      check("t1_count", 32'(instr_count), 32'd2);
      check("t1_busy",  32'(busy), 32'd0);
      check("t1_sb",    32'(exp_q.size()), 32'd0);

      // restart with a byte presented in the same cycle: byte must wait
      bus.in_data  = 8'h10;
      bus.in_valid = 1'b1;
      load_start   = 1'b1;
      check("restart_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      load_start = 1'b0;
      check("restart_cleared", 32'(load_done), 32'd0);
      check("restart_count",   32'(instr_count), 32'd0);
      expect_write(2'd0, 24'h10123A);
      expect_write(2'd1, 24'hF00000);
      send_byte(8'h10);
      @(negedge clk);
      send_byte(8'h12);
      @(negedge clk);
      send_byte(8'h3A);
      // load_start during WRITE and during B0 must be ignored
      pulse_start();
      pulse_start();
      check("busy_start_count", 32'(instr_count), 32'd1);
      check("busy_start_busy",  32'(busy), 32'd1);
      send_word(24'hF00000, 1'b1);
      @(negedge clk);
      check("t2_done",  32'(load_done), 32'd1);
      check("t2_count", 32'(instr_count), 32'd2);
      check("t2_sb",    32'(exp_q.size()), 32'd0);

      // overflow: four non-HALT words fill a 4-word memory
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         expect_write(ADDR_W'(i), 24'h0A0000 + 24'(i));
      end
      for (int i = 0; i < 4; i++) begin
         send_word(24'h0A0000 + 24'(i), (i % 2) == 1);
      end
      @(negedge clk);
      check("ovf_error", 32'(load_error), 32'd1);
      check("ovf_done",  32'(load_done), 32'd0);
      check("ovf_count", 32'(instr_count), 32'd4);
      check("ovf_busy",  32'(busy), 32'd0);
      check("ovf_sb",    32'(exp_q.size()), 32'd0);

      // timeout: two bytes then silence
      pulse_start();
      check("to_err_cleared", 32'(load_error), 32'd0);
      send_byte(8'h12);
      send_byte(8'h34);
      for (int k = 1; k <= TIMEOUT; k++) begin
         @(negedge clk);
         if (k == TIMEOUT - 1) check("to_early", 32'(load_error), 32'd0);
         if (k == TIMEOUT) begin
            check("to_error", 32'(load_error), 32'd1);
            check("to_busy",  32'(busy), 32'd0);
            check("to_count", 32'(instr_count), 32'd0);
         end
      end

      // long pause in B0 is legal
      pulse_start();
      repeat (100) @(negedge clk);
      check("pause_error", 32'(load_error), 32'd0);
      check("pause_busy",  32'(busy), 32'd1);
      expect_write(2'd0, 24'hF00000);
      send_word(24'hF00000, 1'b0);
      @(negedge clk);
      check("pause_done", 32'(load_done), 32'd1);

      // reset in the middle of a word
      pulse_start();
      send_byte(8'h10);
      send_byte(8'h12);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_busy",  32'(busy), 32'd0);
      check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
      check("mid_rst_wdata", 32'(bus.imem_wdata), 32'd0);
      check("mid_rst_addr",  32'(bus.imem_addr), 32'd0);
      check("mid_rst_done",  32'(load_done), 32'd0);
      check("mid_rst_count", 32'(instr_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      pulse_start();
      expect_write(2'd0, 24'hF00000);
      send_word(24'hF00000, 1'b0);
      @(negedge clk);
      check("post_rst_done",  32'(load_done), 32'd1);
      check("post_rst_count", 32'(instr_count), 32'd1);
      repeat (3) @(negedge clk);
      check("final_sb", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
